// File: rtl/output_arbiter_if.sv
// Handshake bundle between the D0/D1 source FIFOs, the output arbiter and the downstream sink.
// The arbiter connects through the master modport; the FIFO/sink side uses slave.
interface output_arbiter_if #(
    parameter int DATA_W = 6
);
    logic [DATA_W-1:0] data_in_0;
    logic [DATA_W-1:0] data_in_1;
    logic              empty_0;
    logic              empty_1;
    logic              pop_0;
    logic              pop_1;
    logic              almost_full_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;

    modport master (
        input  data_in_0,
        input  data_in_1,
        input  empty_0,
        input  empty_1,
        input  almost_full_in,
        output pop_0,
        output pop_1,
        output data_out,
        output valid_out
    );

    modport slave (
        output data_in_0,
        output data_in_1,
        output empty_0,
        output empty_1,
        output almost_full_in,
        input  pop_0,
        input  pop_1,
        input  data_out,
        input  valid_out
    );
endinterface

// File: rtl/output_arbiter.sv
// Weighted round-robin arbiter draining two FIFOs into one output with a two-stage delivery pipe.
// Define ARB_COUNTERS_EN to add the saturating per-class delivered-word counters count_0/count_1.
module output_arbiter #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [3:0]       weight,
    output_arbiter_if.master bus,
    output logic             idle_out,
    output logic             active_out,
    output logic             error_out
`ifdef ARB_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] count_0,
    output logic [CNT_W-1:0] count_1
`endif
);

    typedef enum logic [4:0] {
        S_RESET  = 5'b00001,
        S_INIT   = 5'b00010,
        S_IDLE   = 5'b00100,
        S_ACTIVE = 5'b01000,
        S_ERROR  = 5'b10000
    } state_t;

    if (CNT_W < 1 || CNT_W > 32) begin : gBadCntW
        $error("output_arbiter: CNT_W must be in 1..32");
    end

    state_t            state_q, state_d;
    logic [3:0]        weight_q, weight_d;
    logic [3:0]        runCnt_q, runCnt_d;
    logic              inflightValid_q, inflightValid_d;
    logic              inflightSel_q, inflightSel_d;
    logic              validOut_q, validOut_d;
    logic [DATA_W-1:0] dataOut_q, dataOut_d;
    logic              canPop;
    logic              grant0;
    logic              grant1;

    always_comb begin
        state_d  = state_q;
        weight_d = weight_q;
        if (init && state_q != S_ERROR) begin
            state_d  = S_INIT;
            weight_d = weight;
        end else begin
            unique case (state_q)
                S_RESET:  state_d = S_INIT;
                S_INIT:   state_d = (weight_q == 4'd0) ? S_ERROR : S_IDLE;
                S_IDLE:   if (!bus.empty_0 || !bus.empty_1) state_d = S_ACTIVE;
                S_ACTIVE: if (bus.empty_0 && bus.empty_1) state_d = S_IDLE;
                S_ERROR:  state_d = S_ERROR;
                default:  state_d = S_RESET;
            endcase
        end
    end

    // A pending init blocks new grants; the run counter tracks D0 grants since D1 last won.
    always_comb begin
        canPop   = (state_q == S_ACTIVE) && !bus.almost_full_in && !init;
        grant0   = 1'b0;
        grant1   = 1'b0;
        runCnt_d = runCnt_q;
        if (canPop) begin
            if (!bus.empty_0 && !bus.empty_1) begin
                if (runCnt_q < weight_q) grant0 = 1'b1;
                else                     grant1 = 1'b1;
            end else if (!bus.empty_0) begin
                grant0 = 1'b1;
            end else if (!bus.empty_1) begin
                grant1 = 1'b1;
            end
        end
        if (grant1 || bus.empty_1) runCnt_d = 4'd0;
        else if (grant0)           runCnt_d = runCnt_q + 4'd1;
    end

    // The FIFO presents popped data one edge after the pop, so the selection rides one stage first.
    always_comb begin
        inflightValid_d = grant0 || grant1;
        inflightSel_d   = grant1;
        validOut_d      = inflightValid_q;
        dataOut_d       = dataOut_q;
        if (inflightValid_q) dataOut_d = inflightSel_q ? bus.data_in_1 : bus.data_in_0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_RESET;
            weight_q        <= 4'd0;
            runCnt_q        <= 4'd0;
            inflightValid_q <= 1'b0;
            inflightSel_q   <= 1'b0;
            validOut_q      <= 1'b0;
            dataOut_q       <= '0;
        end else begin
            state_q         <= state_d;
            weight_q        <= weight_d;
            runCnt_q        <= runCnt_d;
            inflightValid_q <= inflightValid_d;
            inflightSel_q   <= inflightSel_d;
            validOut_q      <= validOut_d;
            dataOut_q       <= dataOut_d;
        end
    end

    assign bus.pop_0     = grant0;
    assign bus.pop_1     = grant1;
    assign bus.valid_out = validOut_q;
    assign bus.data_out  = dataOut_q;
    assign idle_out      = (state_q == S_IDLE);
    assign active_out    = (state_q == S_ACTIVE);
    assign error_out     = (state_q == S_ERROR);

`ifdef ARB_COUNTERS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count0_q, count0_d;
    logic [CNT_W-1:0] count1_q, count1_d;

    // Counters advance in step with valid_out so a count is visible with its word.
    always_comb begin
        count0_d = count0_q;
        count1_d = count1_q;
        if (init) begin
            count0_d = '0;
            count1_d = '0;
        end else if (inflightValid_q) begin
            if (!inflightSel_q && count0_q != CNT_MAX) count0_d = count0_q + CNT_ONE;
            if (inflightSel_q && count1_q != CNT_MAX)  count1_d = count1_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count0_q <= '0;
            count1_q <= '0;
        end else begin
            count0_q <= count0_d;
            count1_q <= count1_d;
        end
    end

    assign count_0 = count0_q;
    assign count_1 = count1_q;
`endif

endmodule

// File: tb/tb_output_arbiter.sv
// Bench for output_arbiter: FIFO models on both inputs, a rule-level reference model,
// table-driven grant-order vectors, hand-written corner sequences and a random phase.
module tb_output_arbiter;
    localparam int DATA_W = 6;
    localparam int CNT_W  = 8;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    typedef enum {M_RESET, M_INIT, M_IDLE, M_ACTIVE, M_ERROR} modelState_t;

    typedef struct {
        logic [3:0]  weight;
        int          n0;
        int          n1;
        logic [15:0] order;
    } vector_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init = 1'b0;
    logic [3:0] weight = 4'd0;
    logic       idle_out;
    logic       active_out;
    logic       error_out;
`ifdef ARB_COUNTERS_EN
    logic [CNT_W-1:0] count_0;
    logic [CNT_W-1:0] count_1;
`endif

    output_arbiter_if #(.DATA_W(DATA_W)) bus ();

    output_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .init(init),
        .weight(weight),
        .bus(bus),
        .idle_out(idle_out),
        .active_out(active_out),
        .error_out(error_out)
`ifdef ARB_COUNTERS_EN
        ,
        .count_0(count_0),
        .count_1(count_1)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int validSeen = 0;
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    int popLog[$];

    modelState_t       mState = M_RESET;
    int                mWeight = 0;
    int                mStreak = 0;
    bit                exp1V = 1'b0;
    bit                exp1Src = 1'b0;
    bit                exp2V = 1'b0;
    bit                exp2Src = 1'b0;
    logic [DATA_W-1:0] exp1W = '0;
    logic [DATA_W-1:0] exp2W = '0;
    logic [DATA_W-1:0] mLast = '0;
    int                mCnt0 = 0;
    int                mCnt1 = 0;

    vector_t vectors[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // One clock cycle: compare the DUT to the model at the falling edge, advance the model,
    // then let the FIFO models react to the pops just after the rising edge.
    task automatic applyStimulus(input logic aInit, input logic [3:0] aWeight, input logic aFull);
        logic eP0, eP1, p0, p1;
        bit   e0, e1;
        init = aInit;
        weight = aWeight;
        bus.almost_full_in = aFull;
        @(negedge clk);
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
        eP0 = 1'b0;
        eP1 = 1'b0;
        if (mState == M_ACTIVE && !aFull && !aInit) begin
            if (!e0 && !e1) begin
                if (mStreak < mWeight) eP0 = 1'b1;
                else                   eP1 = 1'b1;
            end else if (!e0) begin
                eP0 = 1'b1;
            end else if (!e1) begin
                eP1 = 1'b1;
            end
        end
        checkOutput("pop_0", 32'(bus.pop_0), 32'(eP0));
        checkOutput("pop_1", 32'(bus.pop_1), 32'(eP1));
        checkOutput("idle_out", 32'(idle_out), 32'(mState == M_IDLE));
        checkOutput("active_out", 32'(active_out), 32'(mState == M_ACTIVE));
        checkOutput("error_out", 32'(error_out), 32'(mState == M_ERROR));
        checkOutput("valid_out", 32'(bus.valid_out), 32'(exp2V));
        checkOutput("data_out", 32'(bus.data_out), 32'(exp2V ? exp2W : mLast));
`ifdef ARB_COUNTERS_EN
        checkOutput("count_0", 32'(count_0), 32'(mCnt0));
        checkOutput("count_1", 32'(count_1), 32'(mCnt1));
`endif
        p0 = bus.pop_0;
        p1 = bus.pop_1;
        if (p0) popLog.push_back(0);
        if (p1) popLog.push_back(1);
        if (bus.valid_out) validSeen++;

        if (exp2V) mLast = exp2W;
        if (aInit) begin
            mCnt0 = 0;
            mCnt1 = 0;
        end else if (exp1V) begin
            if (exp1Src) begin
                if (mCnt1 < CNT_SAT) mCnt1++;
            end else begin
                if (mCnt0 < CNT_SAT) mCnt0++;
            end
        end
        exp2V = exp1V;
        exp2Src = exp1Src;
        exp2W = exp1W;
        exp1V = eP0 || eP1;
        exp1Src = eP1;
        exp1W = '0;
        if (eP1) exp1W = q1[0];
        else if (eP0) exp1W = q0[0];
        if (eP1 || e1) mStreak = 0;
        else if (eP0) mStreak++;
        if (aInit && mState != M_ERROR) begin
            mState = M_INIT;
            mWeight = int'(aWeight);
        end else begin
            case (mState)
                M_RESET:  mState = M_INIT;
                M_INIT:   mState = (mWeight == 0) ? M_ERROR : M_IDLE;
                M_IDLE:   if (!e0 || !e1) mState = M_ACTIVE;
                M_ACTIVE: if (e0 && e1) mState = M_IDLE;
                default:  mState = mState;
            endcase
        end

        @(posedge clk);
        #1;
        if (p0 && q0.size() > 0) bus.data_in_0 = q0.pop_front();
        if (p1 && q1.size() > 0) bus.data_in_1 = q1.pop_front();
        bus.empty_0 = (q0.size() == 0);
        bus.empty_1 = (q1.size() == 0);
    endtask

    task automatic loadFifos(input int n0, input int n1);
        for (int i = 0; i < n0; i++) q0.push_back({1'b0, (DATA_W-1)'($urandom)});
        for (int i = 0; i < n1; i++) q1.push_back({1'b1, (DATA_W-1)'($urandom)});
        bus.empty_0 = (q0.size() == 0);
        bus.empty_1 = (q1.size() == 0);
    endtask

    // Reset is asserted between clock edges so the output checks prove it acts without clk.
    task automatic doReset();
        reset = 1'b0;
        #1;
        checkOutput("rst_pop_0", 32'(bus.pop_0), 32'(0));
        checkOutput("rst_pop_1", 32'(bus.pop_1), 32'(0));
        checkOutput("rst_valid_out", 32'(bus.valid_out), 32'(0));
        checkOutput("rst_data_out", 32'(bus.data_out), 32'(0));
        checkOutput("rst_idle_out", 32'(idle_out), 32'(0));
        checkOutput("rst_active_out", 32'(active_out), 32'(0));
        checkOutput("rst_error_out", 32'(error_out), 32'(0));
`ifdef ARB_COUNTERS_EN
        checkOutput("rst_count_0", 32'(count_0), 32'(0));
        checkOutput("rst_count_1", 32'(count_1), 32'(0));
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        mState = M_RESET;
        mWeight = 0;
        mStreak = 0;
        exp1V = 1'b0;
        exp1Src = 1'b0;
        exp2V = 1'b0;
        exp2Src = 1'b0;
        mLast = '0;
        mCnt0 = 0;
        mCnt1 = 0;
        q0.delete();
        q1.delete();
        bus.empty_0 = 1'b1;
        bus.empty_1 = 1'b1;
        init = 1'b0;
        bus.almost_full_in = 1'b0;
    endtask

    initial begin
        bus.data_in_0 = '0;
        bus.data_in_1 = '0;
        bus.empty_0 = 1'b1;
        bus.empty_1 = 1'b1;
        bus.almost_full_in = 1'b0;

        // order bit i is the i-th grant, 1 meaning D1
        vectors[0] = '{4'd2, 4, 4, 16'h00E4};
        vectors[1] = '{4'd1, 3, 3, 16'h002A};
        vectors[2] = '{4'd3, 2, 3, 16'h001C};
        vectors[3] = '{4'd2, 5, 2, 16'h0024};
        vectors[4] = '{4'd4, 0, 3, 16'h0007};
        vectors[5] = '{4'd2, 5, 3, 16'h00A4};

        #2;
        for (int v = 0; v < 6; v++) begin
            doReset();
            applyStimulus(1'b1, vectors[v].weight, 1'b0);
            applyStimulus(1'b0, vectors[v].weight, 1'b0);
            checkOutput($sformatf("v%0d_idle", v), 32'(idle_out), 32'(1));
            popLog.delete();
            loadFifos(vectors[v].n0, vectors[v].n1);
            for (int c = 0; c < vectors[v].n0 + vectors[v].n1 + 6; c++)
                applyStimulus(1'b0, vectors[v].weight, 1'b0);
            checkOutput($sformatf("v%0d_orderLen", v), 32'(popLog.size()),
                        32'(vectors[v].n0 + vectors[v].n1));
            for (int i = 0; i < popLog.size() && i < 16; i++)
                checkOutput($sformatf("v%0d_order%0d", v, i), 32'(popLog[i]), 32'(vectors[v].order[i]));
            checkOutput($sformatf("v%0d_idleAfter", v), 32'(idle_out), 32'(1));
        end

`ifdef ARB_COUNTERS_EN
        checkOutput("cnt_total_0", 32'(count_0), 32'(5));
        checkOutput("cnt_total_1", 32'(count_1), 32'(3));
        applyStimulus(1'b1, 4'd2, 1'b0);
        applyStimulus(1'b0, 4'd2, 1'b0);
        checkOutput("cnt_cleared_0", 32'(count_0), 32'(0));
        checkOutput("cnt_cleared_1", 32'(count_1), 32'(0));
`endif

        $display("[TB] backpressure sequence");
        doReset();
        applyStimulus(1'b1, 4'd2, 1'b0);
        applyStimulus(1'b0, 4'd2, 1'b0);
        loadFifos(4, 4);
        repeat (3) applyStimulus(1'b0, 4'd2, 1'b0);
        popLog.delete();
        applyStimulus(1'b0, 4'd2, 1'b1);
        validSeen = 0;
        repeat (4) applyStimulus(1'b0, 4'd2, 1'b1);
        checkOutput("bp_pops", 32'(popLog.size()), 32'(0));
        checkOutput("bp_inflight", 32'(validSeen), 32'(1));
        applyStimulus(1'b0, 4'd2, 1'b0);
        checkOutput("bp_resume", 32'(popLog.size()), 32'(1));
        repeat (12) applyStimulus(1'b0, 4'd2, 1'b0);

        $display("[TB] error sequence");
        doReset();
        applyStimulus(1'b1, 4'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        loadFifos(2, 2);
        popLog.delete();
        repeat (4) applyStimulus(1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 4'd3, 1'b0);
        repeat (3) applyStimulus(1'b0, 4'd3, 1'b0);
        checkOutput("err_sticky", 32'(error_out), 32'(1));
        checkOutput("err_pops", 32'(popLog.size()), 32'(0));

        $display("[TB] random sequence");
        doReset();
        applyStimulus(1'b1, 4'd3, 1'b0);
        applyStimulus(1'b0, 4'd3, 1'b0);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 8) q0.push_back({1'b0, (DATA_W-1)'($urandom)});
            if ($urandom_range(0, 2) == 0 && q1.size() < 8) q1.push_back({1'b1, (DATA_W-1)'($urandom)});
            bus.empty_0 = (q0.size() == 0);
            bus.empty_1 = (q1.size() == 0);
            if (c == 300) begin
                #2;
                doReset();
                applyStimulus(1'b1, 4'd2, 1'b0);
            end
            applyStimulus(($urandom_range(0, 59) == 0), 4'($urandom_range(1, 15)),
                          ($urandom_range(0, 3) == 0));
        end
        q0.delete();
        q1.delete();
        bus.empty_0 = 1'b1;
        bus.empty_1 = 1'b1;
        repeat (6) applyStimulus(1'b0, 4'd3, 1'b0);
        checkOutput("rand_idleAfter", 32'(idle_out), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 6, meaning the data word width.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the per-class word counters.
REQ-003 The block SHALL have ports: clk input 1 (sole clock, rising edge); reset input 1 (asynchronous, active-low).
REQ-004 The block SHALL have ports: init input 1 (latch configuration); weight input 4 (consecutive D0 grants allowed before yielding to D1).
REQ-005 The block SHALL have ports: data_in_0 and data_in_1, each input DATA_W, read data from the D0 and D1 FIFOs; empty_0 and empty_1, each input 1, FIFO empty flags.
REQ-006 The block SHALL have ports: pop_0 and pop_1, each output 1 (FIFO pops); almost_full_in input 1 (downstream backpressure).
REQ-007 The block SHALL have ports: data_out output DATA_W; valid_out output 1; idle_out, active_out and error_out, each output 1 (state flags).
REQ-008 The block SHALL have ports: count_0 and count_1, each output CNT_W, present only with ARB_COUNTERS_EN defined.

Function
REQ-009 The FSM SHALL have states RESET, INIT, IDLE, ACTIVE and ERROR, encoded one-hot.
REQ-010 The FSM SHALL move from RESET to INIT on the first edge after reset deasserts.
REQ-011 In any state except ERROR, init=1 SHALL load weight into an internal register and move the FSM to INIT.
REQ-012 From INIT with init=0, the FSM SHALL go to ERROR if the latched weight is 0, otherwise to IDLE.
REQ-013 From IDLE, the FSM SHALL go to ACTIVE when either empty flag is 0; from ACTIVE, it SHALL go to IDLE when both empty flags are 1.
REQ-014 ERROR SHALL be sticky until reset.
REQ-015 Flags: idle_out=1 only in IDLE; active_out=1 only in ACTIVE; error_out=1 only in ERROR.
REQ-016 pop_x SHALL be combinational and SHALL assert only in ACTIVE, with empty_x=0 and almost_full_in=0.
REQ-017 At most one pop SHALL assert per cycle.
REQ-018 A pop SHALL never assert on an empty FIFO.
REQ-019 Arbitration SHALL be weighted round-robin: D0 receives up to weight consecutive grants while D1 is non-empty, then D1 receives exactly one grant.
REQ-020 When only one FIFO is non-empty, that FIFO SHALL be granted every eligible cycle.
REQ-021 The run counter SHALL reset to 0 on every D1 grant, and on any cycle in which D1 is empty.
REQ-022 Latency: for a pop sampled at edge E, data_in_x is valid after E, and data_out/valid_out=1 SHALL register at edge E+1.
REQ-023 valid_out SHALL be 0 in every other cycle, and data_out SHALL hold its last value.
REQ-024 Backpressure: the downstream block SHALL tolerate 2 in-flight words after it raises almost_full_in; no pop SHALL issue while almost_full_in=1.
REQ-025 A pop already issued SHALL always complete with valid_out; no word is dropped or duplicated.
REQ-026 init asserted mid-traffic SHALL stop new pops but SHALL still deliver in-flight words.

Reset
REQ-027 With reset=0, all outputs SHALL be 0 and the FSM SHALL be in RESET.
REQ-028 Reset assertion SHALL act immediately, without waiting for clk.
REQ-029 Reset SHALL clear the latched weight, the run counter and the in-flight pipeline.
REQ-030 Deassertion SHALL be sampled on clk.

Configuration
REQ-031 With ARB_COUNTERS_EN defined, count_0 and count_1 SHALL increment on each valid_out from D0 and D1 respectively, SHALL saturate at 2^CNT_W-1, and SHALL be cleared by reset or init.
REQ-032 Without ARB_COUNTERS_EN, the count ports and their logic SHALL be absent, with no other functional change.

Verification
REQ-033 Scenario: reset low for 2 cycles, then weight=2 with an init pulse -> INIT, then IDLE, with all outputs 0 until then.
REQ-034 Scenario: weight=2, both FIFOs loaded with 4 words, almost_full_in=0 -> grant order D0,D0,D1,D0,D0,D1,D1,D1; each valid_out comes 2 edges after its pop.
REQ-035 Scenario: only D1 loaded with 3 words -> 3 consecutive pop_1 pulses, then the FSM returns to IDLE after D1 empties.
REQ-036 Scenario: almost_full_in raised during a pop -> no further pops; exactly 1 in-flight valid_out; pops resume the cycle after it drops.
REQ-037 Scenario: weight=0 with an init pulse -> ERROR, error_out=1, no pops despite FIFO data, cleared only by reset.
REQ-038 Scenario: with ARB_COUNTERS_EN, 5 D0 and 3 D1 words transferred -> count_0=5 and count_1=3; an init pulse clears both to 0.
